// File: rtl/tally_2d_accum.sv
// Frame accumulator for per-row tallies: running total, first maximum, zero-row count
// and an over-range flag, with the result held until the consumer takes it.
//
// state | meaning
// ACCUM | collecting rows, outputs show running partial values
// HOLD  | frame complete, result presented on done_valid until done_ready
module tally_2d_accum #(
  parameter int ROWS = 12,
  parameter int MAXC = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [3:0] count,
  input  logic       count_valid,
  output logic       count_ready,
  output logic [7:0] total,
  output logic [3:0] max_count,
  output logic [3:0] max_row,
  output logic [3:0] zero_rows,
  output logic       err,
  output logic       done_valid,
  input  logic       done_ready
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       ready_en;
  logic       accept;
  logic       last_row;
  logic       release_hold;
  logic [3:0] row_idx;
  logic [3:0] eff;

  assign accept       = count_valid && count_ready;
  assign eff          = (count > 4'(MAXC)) ? 4'(MAXC) : count;
  assign last_row     = (row_idx == 4'(ROWS - 1));
  assign release_hold = (state == HOLD) && done_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last_row) state_nxt = HOLD;
        HOLD:    if (done_ready)         state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_comb begin
    count_ready = (state == ACCUM) && !clear && ready_en;
    done_valid  = (state == HOLD);
  end

  // Keeps count_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx   <= '0;
      total     <= '0;
      max_count <= '0;
      max_row   <= '0;
      zero_rows <= '0;
      err       <= 1'b0;
    end else if (clear || release_hold) begin
      row_idx   <= '0;
      total     <= '0;
      max_count <= '0;
      max_row   <= '0;
      zero_rows <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      total <= total + 8'(eff);
      if (eff == 4'd0)       zero_rows <= zero_rows + 4'd1;
      if (count > 4'(MAXC))  err       <= 1'b1;
      // Strictly greater keeps the earliest row on ties.
      if (eff > max_count) begin
        max_count <= eff;
        max_row   <= row_idx;
      end
      if (!last_row) row_idx <= row_idx + 4'd1;
    end
  end

endmodule
